// File: rtl/fetch_stage.sv
// Instruction-fetch control and IF/ID latch: sequential fetch, branch/jump redirects,
// decode stalls and halt. A redirect that arrives while a read is outstanding is parked.
module fetch_stage #(
  parameter logic [31:0] PC_INCR   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] current_pc,
  output logic        pc_wen,
  output logic [31:0] next_pc,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  input  logic        halt,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {StFetch, StDrop, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic [31:0] seq_pc;

  assign seq_pc     = current_pc + PC_INCR;
  assign imemaddr   = current_pc;
  assign ifid_instr = instr_q;
  assign ifid_npc   = npc_q;
  assign ifid_valid = valid_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StFetch;
      pend_q  <= '0;
      instr_q <= NOP_INSTR;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    pc_wen  = 1'b0;
    next_pc = seq_pc;
    imemREN = (state_q != StHalt);

    unique case (state_q)
      StFetch: begin
        if (halt) begin
          state_d = StHalt;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (redirect_en) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (ihit) begin
            pc_wen  = 1'b1;
            next_pc = redirect_pc;
          end else begin
            // Read still in flight: wait for it before retargeting the PC.
            pend_d  = redirect_pc;
            state_d = StDrop;
          end
        end else if (ihit) begin
          if (!id_stall) begin
            pc_wen  = 1'b1;
            instr_d = imemload;
            npc_d   = seq_pc;
            valid_d = 1'b1;
          end
        end else if (!id_stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      StDrop: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        if (halt) begin
          state_d = StHalt;
        end else if (ihit) begin
          pc_wen  = 1'b1;
          next_pc = redirect_en ? redirect_pc : pend_q;
          state_d = StFetch;
        end else if (redirect_en) begin
          pend_d = redirect_pc;
        end
      end
      StHalt: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays the PC register and imem, and checks
// comb outputs #1 after inputs change and registered outputs #1 after each rising edge.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] current_pc;
  logic        pc_wen;
  logic [31:0] next_pc;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        halt;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .current_pc (current_pc),
    .pc_wen     (pc_wen),
    .next_pc    (next_pc),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .id_stall   (id_stall),
    .halt       (halt),
    .ifid_instr (ifid_instr),
    .ifid_npc   (ifid_npc),
    .ifid_valid (ifid_valid)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit        = 1'b0;
    imemload    = 32'h0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    id_stall    = 1'b0;
    halt        = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    current_pc = 32'h0;
    nRST = 1'b0;
    #1;
    total++;
    if (ifid_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got %b want 0", ifid_valid);
    end
    total++;
    if (ifid_instr !== 32'h0 || ifid_npc !== 32'h0) begin
      bad++; $display("FAIL reset_ifid got %h/%h want 0/0", ifid_instr, ifid_npc);
    end
    total++;
    if (imemREN !== 1'b1 || pc_wen !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got ren=%b wen=%b want 1/0", imemREN, pc_wen);
    end
    tick();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] data [3];
    logic [31:0] npc [3];
    data = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    npc  = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      current_pc = 32'h4 * i;
      ihit = 1'b1;
      imemload = data[i];
      #1;
      total++;
      if (pc_wen !== 1'b1 || next_pc !== npc[i] || imemaddr !== current_pc) begin
        bad++;
        $display("FAIL seq_comb[%0d] got wen=%b npc=%h addr=%h want 1/%h/%h",
                 i, pc_wen, next_pc, imemaddr, npc[i], current_pc);
      end
      tick();
      total++;
      if (ifid_instr !== data[i] || ifid_npc !== npc[i] || ifid_valid !== 1'b1) begin
        bad++;
        $display("FAIL seq_ifid[%0d] got %h/%h/%b want %h/%h/1",
                 i, ifid_instr, ifid_npc, ifid_valid, data[i], npc[i]);
      end
    end
  endtask

  task automatic test_stall();
    current_pc = 32'h10;
    ihit = 1'b1;
    imemload = 32'hDDDD_0004;
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (pc_wen !== 1'b0) begin
        bad++; $display("FAIL stall_wen[%0d] got %b want 0", i, pc_wen);
      end
      tick();
      total++;
      if (ifid_instr !== 32'hCCCC_0003 || ifid_npc !== 32'hC || ifid_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_frozen[%0d] got %h/%h/%b want cccc0003/0000000c/1",
                 i, ifid_instr, ifid_npc, ifid_valid);
      end
    end
    id_stall = 1'b0;
    #1;
    total++;
    if (pc_wen !== 1'b1 || next_pc !== 32'h14) begin
      bad++; $display("FAIL stall_release got wen=%b npc=%h want 1/00000014", pc_wen, next_pc);
    end
    tick();
    total++;
    if (ifid_instr !== 32'hDDDD_0004 || ifid_npc !== 32'h14 || ifid_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_capture got %h/%h/%b want dddd0004/00000014/1",
               ifid_instr, ifid_npc, ifid_valid);
    end
  endtask

  task automatic test_drop();
    current_pc = 32'h14;
    ihit = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    #1;
    total++;
    if (pc_wen !== 1'b0) begin
      bad++; $display("FAIL drop_enter_wen got %b want 0", pc_wen);
    end
    tick();
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    total++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      bad++; $display("FAIL drop_flush got %b/%h want 0/00000000", ifid_valid, ifid_instr);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (pc_wen !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h14) begin
        bad++;
        $display("FAIL drop_wait[%0d] got wen=%b ren=%b addr=%h want 0/1/00000014",
                 i, pc_wen, imemREN, imemaddr);
      end
      tick();
    end
    ihit = 1'b1;
    imemload = 32'hBAD0_BAD0;
    #1;
    total++;
    if (pc_wen !== 1'b1 || next_pc !== 32'h40) begin
      bad++; $display("FAIL drop_complete got wen=%b npc=%h want 1/00000040", pc_wen, next_pc);
    end
    tick();
    total++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      bad++; $display("FAIL drop_stale got %b/%h want 0/00000000", ifid_valid, ifid_instr);
    end
    current_pc = 32'h40;
    imemload = 32'hEEEE_0005;
    #1;
    total++;
    if (pc_wen !== 1'b1 || next_pc !== 32'h44) begin
      bad++; $display("FAIL drop_resume got wen=%b npc=%h want 1/00000044", pc_wen, next_pc);
    end
    tick();
    total++;
    if (ifid_instr !== 32'hEEEE_0005 || ifid_npc !== 32'h44 || ifid_valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_resume_ifid got %h/%h/%b want eeee0005/00000044/1",
               ifid_instr, ifid_npc, ifid_valid);
    end
  endtask

  task automatic test_redirect_stall();
    current_pc = 32'h44;
    ihit = 1'b1;
    id_stall = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h80;
    #1;
    total++;
    if (pc_wen !== 1'b1 || next_pc !== 32'h80) begin
      bad++; $display("FAIL redir_stall got wen=%b npc=%h want 1/00000080", pc_wen, next_pc);
    end
    tick();
    total++;
    if (ifid_valid !== 1'b0) begin
      bad++; $display("FAIL redir_stall_valid got %b want 0", ifid_valid);
    end
    // Two redirects while the read is outstanding: the newer target must win.
    current_pc = 32'h80;
    id_stall = 1'b0;
    ihit = 1'b0;
    redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h200;
    tick();
    redirect_en = 1'b0;
    ihit = 1'b1;
    #1;
    total++;
    if (pc_wen !== 1'b1 || next_pc !== 32'h200) begin
      bad++; $display("FAIL redir_newest got wen=%b npc=%h want 1/00000200", pc_wen, next_pc);
    end
    tick();
  endtask

  task automatic test_halt_wrap();
    current_pc = 32'hFFFF_FFFC;
    ihit = 1'b1;
    imemload = 32'h1234_5678;
    #1;
    total++;
    if (pc_wen !== 1'b1 || next_pc !== 32'h0) begin
      bad++; $display("FAIL wrap got wen=%b npc=%h want 1/00000000", pc_wen, next_pc);
    end
    tick();
    total++;
    if (ifid_npc !== 32'h0 || ifid_instr !== 32'h1234_5678) begin
      bad++; $display("FAIL wrap_ifid got %h/%h want 00000000/12345678", ifid_npc, ifid_instr);
    end
    current_pc = 32'h20;
    ihit = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_en = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    ihit = 1'b1;
    redirect_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (imemREN !== 1'b0 || pc_wen !== 1'b0 || ifid_valid !== 1'b0) begin
        bad++;
        $display("FAIL halt_hold[%0d] got ren=%b wen=%b valid=%b want 0/0/0",
                 i, imemREN, pc_wen, ifid_valid);
      end
      tick();
    end
    idle_inputs();
    nRST = 1'b0;
    #1;
    total++;
    if (imemREN !== 1'b1) begin
      bad++; $display("FAIL halt_exit got ren=%b want 1", imemREN);
    end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    current_pc = 32'h60;
    ihit = 1'b1;
    imemload = 32'h5555_0006;
    tick();
    ihit = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h500;
    tick();
    redirect_en = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    total++;
    if (ifid_npc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      bad++;
      $display("FAIL async_reset got %h/%b/%h want 00000000/0/00000000",
               ifid_npc, ifid_valid, ifid_instr);
    end
    ihit = 1'b1;
    #1;
    total++;
    if (next_pc !== 32'h64 || pc_wen !== 1'b1) begin
      bad++; $display("FAIL async_no_pend got wen=%b npc=%h want 1/00000064", pc_wen, next_pc);
    end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_drop();
    test_redirect_stall();
    test_halt_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
